lmu_rom_ctrl: RTL and testbench

LMU_ROM_CTRL -- requirements
Module: lmu_rom_ctrl

---
 rtl/lmu_rom_pkg.sv | 31 +++
 rtl/lmu_rom_array.sv | 54 +++++
 rtl/lmu_rom_ctrl.sv | 119 +++++++++++
 tb/tb_lmu_rom_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lmu_rom_pkg.sv
// Shared response type and latency/depth helpers for the LMU ROM controller.
// Build option: LMU_ROM_PARITY_EN adds one even-parity bit per stored word.
package lmu_rom_pkg;

  localparam int unsigned LMU_MAX_DW   = 128;
  localparam logic [7:0]  LMU_ROM_FILL = 8'hA5;

`ifdef LMU_ROM_PARITY_EN
  localparam int unsigned LMU_PAR_W = 1;
`else
  localparam int unsigned LMU_PAR_W = 0;
`endif

  typedef struct packed {
    logic [LMU_MAX_DW-1:0] data;
    logic                  err;
  } lmu_resp_t;

  function automatic int unsigned lmu_read_lat(input int unsigned out_regs);
    return (out_regs != 0) ? 2 : 1;
  endfunction

  function automatic int unsigned lmu_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned lmu_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lmu_rom_array.sv
// Synchronous read-only word array with read enable and optional output register.
// Build options: LMU_ROM_PARITY_EN (stores a parity bit), LMU_ROM_FPGA (block-ROM inference hint).
module lmu_rom_array
  import lmu_rom_pkg::*;
#(
  parameter  int unsigned NUM_WORDS  = 32768,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned OUT_REGS   = 0,
  localparam int unsigned IW         = $clog2(NUM_WORDS),
  localparam int unsigned SW         = DATA_WIDTH + LMU_PAR_W
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [IW-1:0] i_addr,
  output logic [SW-1:0] o_rdata
);

  localparam int unsigned LOW_W = (DATA_WIDTH < 16) ? DATA_WIDTH : 16;

  // Image: every byte 0xA5, low 16 bits carry the word index.
  function automatic logic [SW-1:0] rom_word(input logic [IW-1:0] a);
    logic [DATA_WIDTH-1:0] d;
    logic [15:0]           a16;
    d   = {(DATA_WIDTH/8){LMU_ROM_FILL}};
    a16 = 16'(a);
    for (int unsigned b = 0; b < LOW_W; b++) d[b] = a16[b];
`ifdef LMU_ROM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

`ifdef LMU_ROM_FPGA
  (* rom_style = "block" *) logic [SW-1:0] r_word;
`else
  logic [SW-1:0] r_word;
`endif

  always_ff @(posedge i_clk) begin
    if (i_en) r_word <= rom_word(i_addr);
  end

  if (OUT_REGS != 0) begin : g_oreg
    logic [SW-1:0] r_word_q;
    always_ff @(posedge i_clk) begin
      r_word_q <= r_word;
    end
    assign o_rdata = r_word_q;
  end else begin : g_no_oreg
    assign o_rdata = r_word;
  end

endmodule

// File: rtl/lmu_rom_ctrl.sv
// LMU ROM read controller: req/gnt front end, fixed-latency array pipeline, in-order response FIFO.
// Build option: LMU_ROM_PARITY_EN checks per-word even parity and reports mismatches on rerr_o.
module lmu_rom_ctrl
  import lmu_rom_pkg::*;
#(
  parameter  int unsigned NUM_WORDS  = 32768,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned OUT_REGS   = 0,
  parameter  int unsigned RESP_DEPTH = 2,
  localparam int unsigned AW         = $clog2(NUM_WORDS) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [AW-1:0]         addr_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rerr_o
);

  localparam int unsigned LAT = lmu_read_lat(OUT_REGS);
  localparam int unsigned IW  = AW - 1;
  localparam int unsigned SW  = DATA_WIDTH + LMU_PAR_W;
  localparam int unsigned CW  = lmu_cnt_w(RESP_DEPTH);
  localparam int unsigned PW  = lmu_ptr_w(RESP_DEPTH);

  logic            w_accept;
  logic            w_arr_en;
  logic            w_push;
  logic            w_pop;
  logic            w_oor;
  logic            w_par_err;
  logic [SW-1:0]   w_arr_rdata;
  logic [CW:0]     w_occ;
  logic [LAT-1:0]  r_vpipe;
  logic [LAT-1:0]  r_opipe;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  lmu_resp_t       r_mem [RESP_DEPTH];
  lmu_resp_t       w_push_resp;
  lmu_resp_t       w_head;
  logic            w_unused_hi;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Everything accepted but not yet popped reserves a FIFO slot, so a push can never overflow.
  assign w_pop    = rvalid_o & rready_i;
  assign w_occ    = {1'b0, r_inflight} + {1'b0, r_count} - {{CW{1'b0}}, w_pop};
  assign gnt_o    = rst_ni & (w_occ < (CW+1)'(RESP_DEPTH));
  assign w_accept = req_i & gnt_o;
  assign w_arr_en = w_accept & ~addr_i[AW-1];

  lmu_rom_array #(
    .NUM_WORDS (NUM_WORDS),
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_REGS  (OUT_REGS)
  ) u_array (
    .i_clk  (clk_i),
    .i_en   (w_arr_en),
    .i_addr (addr_i[IW-1:0]),
    .o_rdata(w_arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vpipe <= '0;
      r_opipe <= '0;
    end else begin
      r_vpipe <= LAT'({r_vpipe, w_accept});
      r_opipe <= LAT'({r_opipe, addr_i[AW-1]});
    end
  end

  assign w_push = r_vpipe[LAT-1];
  assign w_oor  = r_opipe[LAT-1];

`ifdef LMU_ROM_PARITY_EN
  assign w_par_err = ~w_oor & (^w_arr_rdata);
`else
  assign w_par_err = 1'b0;
`endif

  always_comb begin
    w_push_resp     = '0;
    w_push_resp.err = w_oor | w_par_err;
    if (!w_oor) w_push_resp.data = LMU_MAX_DW'(w_arr_rdata[DATA_WIDTH-1:0]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_push_resp;
  end

  assign w_head      = r_mem[r_rptr];
  assign rvalid_o    = (r_count != '0);
  assign rdata_o     = rvalid_o ? w_head.data[DATA_WIDTH-1:0] : '0;
  assign rerr_o      = rvalid_o & w_head.err;
  assign w_unused_hi = |(w_head.data >> DATA_WIDTH);

endmodule

// File: tb/tb_lmu_rom_ctrl.sv
// Bench for lmu_rom_ctrl: two configurations, queue-based response model plus directed literal checks.
module tb_lmu_rom_ctrl;

  localparam int unsigned NW = 64;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = $clog2(NW) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  for (genvar c = 0; c < 2; c++) begin : g_cfg
    localparam int unsigned OREG  = c;
    localparam int unsigned DEPTH = 2 + c;
    localparam int unsigned LAT   = 1 + OREG;

    logic          rst_n, req, gnt, rvalid, rready, rerr;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic          fin = 1'b0;

    lmu_rom_ctrl #(
      .NUM_WORDS (NW),
      .DATA_WIDTH(DW),
      .OUT_REGS  (OREG),
      .RESP_DEPTH(DEPTH)
    ) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req),
      .gnt_o   (gnt),
      .addr_i  (addr),
      .rvalid_o(rvalid),
      .rready_i(rready),
      .rdata_o (rdata),
      .rerr_o  (rerr)
    );

    function automatic string nm(input string s);
      return $sformatf("cfg%0d_%s", c, s);
    endfunction

    function automatic logic [DW-1:0] ref_word(input int unsigned a);
      return (a >= NW) ? '0 : (32'hA5A5_0000 | DW'(a));
    endfunction

    // Model: every accepted read is outstanding until popped; it becomes visible LAT edges after its accepting edge.
    typedef struct {
      logic [DW-1:0] data;
      logic          err;
      longint        ready;
    } exp_t;
    exp_t   q[$];
    longint edge_n = 0;
    logic   exp_gnt = 1'b0;
    logic   exp_vld = 1'b0;

    initial begin
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          q.delete();
          exp_gnt = 1'b0;
          exp_vld = 1'b0;
          chk(nm("rst_gnt"), gnt, 0);
          chk(nm("rst_rvalid"), rvalid, 0);
          chk(nm("rst_rdata"), rdata, 0);
          chk(nm("rst_rerr"), rerr, 0);
        end else begin
          exp_vld = (q.size() > 0) && (q[0].ready <= edge_n);
          exp_gnt = ((q.size() - ((exp_vld && rready) ? 1 : 0)) < DEPTH);
          chk(nm("gnt"), gnt, exp_gnt);
          chk(nm("rvalid"), rvalid, exp_vld);
          if (exp_vld) begin
            chk(nm("rdata"), rdata, q[0].data);
            chk(nm("rerr"), rerr, q[0].err);
          end
          chk(nm("arr_en"), u_dut.w_arr_en, req && exp_gnt && (addr < NW));
        end
        @(posedge clk);
        if (rst_n === 1'b1) begin
          edge_n++;
          if (exp_vld && rready) void'(q.pop_front());
          if (req && exp_gnt) q.push_back('{ref_word(addr), (addr >= NW), edge_n + LAT});
        end else begin
          q.delete();
        end
      end
    end

    task automatic single_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e,
                               input string tag);
      int unsigned cnt;
      @(posedge clk); #1;
      req = 1'b1; addr = a; rready = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      cnt = 0;
      while (rvalid !== 1'b1 && cnt < 10) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk(nm({tag, "_lat"}), cnt, LAT);
      chk(nm({tag, "_data"}), rdata, d);
      chk(nm({tag, "_err"}), rerr, e);
    endtask

    initial begin
      int unsigned cnt;
      rst_n = 1'b0; req = 1'b0; rready = 1'b1; addr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk(nm("init_gnt"), gnt, 0);
      chk(nm("init_rvalid"), rvalid, 0);
      rst_n = 1'b1;

      single_read(7'd5,  32'hA5A5_0005, 1'b0, "addr5");
      single_read(7'd9,  32'hA5A5_0009, 1'b0, "addr9");
      single_read(7'd63, 32'hA5A5_003F, 1'b0, "addr_last");
      single_read(7'd64, 32'h0000_0000, 1'b1, "addr_oor");

      // Consumer stalled: only DEPTH grants may be issued.
      @(posedge clk); #1;
      rready = 1'b0; req = 1'b1; addr = 7'd10;
      cnt = 0;
      repeat (6) begin
        @(negedge clk);
        if (gnt === 1'b1) cnt++;
        @(posedge clk); #1;
        addr = addr + 7'd1;
      end
      chk(nm("stall_grants"), cnt, DEPTH);
      @(negedge clk);
      chk(nm("stall_gnt_low"), gnt, 0);
      chk(nm("stall_head"), rdata, 32'hA5A5_000A);
      @(posedge clk); #1;
      rready = 1'b1;
      @(negedge clk);
      chk(nm("pop_regrant"), gnt, 1);
      @(posedge clk); #1;
      req = 1'b0;
      repeat (8) @(posedge clk);

      // Reset with two responses pending.
      #1;
      rready = 1'b0; req = 1'b1; addr = 7'd1;
      @(posedge clk); #1;
      addr = 7'd2;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk(nm("pre_rst_rvalid"), rvalid, 1);
      rst_n = 1'b0;
      #1;
      chk(nm("async_rvalid"), rvalid, 0);
      chk(nm("async_gnt"), gnt, 0);
      chk(nm("async_rdata"), rdata, 0);
      chk(nm("async_rerr"), rerr, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; rready = 1'b1;
      repeat (6) begin
        @(negedge clk);
        chk(nm("no_stale"), rvalid, 0);
      end

      for (int i = 0; i < 600; i++) begin
        @(posedge clk); #1;
        req    = ($urandom_range(0, 3) != 0);
        addr   = AW'($urandom_range(0, NW + 15));
        rready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      req = 1'b0; rready = 1'b1;
      repeat (10) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int unsigned cyc = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got %0d cycles without completion, required completion", cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
